// File: rtl/video_timing_pkg.sv
// Shared config-word layout for the video timing generator and capture frontend.
// unpack_cfg turns the three packed config words into one struct of timing fields.
package video_timing_pkg;

   localparam int H_TOTAL_LSB      = 0;
   localparam int H_ACTIVE_LSB     = 12;
   localparam int H_SYNCLEN_LSB    = 24;
   localparam int H_BACKPORCH_LSB  = 0;
   localparam int V_TOTAL_LSB      = 9;
   localparam int V_ACTIVE_LSB     = 20;
   localparam int INTERLACED_BIT   = 31;
   localparam int V_SYNCLEN_LSB    = 0;
   localparam int V_BACKPORCH_LSB  = 4;
   localparam int V_LOCK_LINE_LSB  = 13;
   localparam int FRAMELOCK_EN_BIT = 24;

   localparam logic FID_ODD  = 1'b1;
   localparam logic FID_EVEN = 1'b0;

   typedef struct packed {
      logic [11:0] h_total;
      logic [11:0] h_active;
      logic [7:0]  h_synclen;
      logic [8:0]  h_backporch;
      logic [10:0] v_total;
      logic [10:0] v_active;
      logic        interlaced;
      logic [3:0]  v_synclen;
      logic [8:0]  v_backporch;
      logic [10:0] v_lock_line;
      logic        framelock_en;
   } vt_cfg_t;

   function automatic vt_cfg_t unpack_cfg(input logic [31:0] cfg1,
                                          input logic [31:0] cfg2,
                                          input logic [31:0] cfg3);
      vt_cfg_t c;
      c.h_total      = cfg1[H_TOTAL_LSB +: 12];
      c.h_active     = cfg1[H_ACTIVE_LSB +: 12];
      c.h_synclen    = cfg1[H_SYNCLEN_LSB +: 8];
      c.h_backporch  = cfg2[H_BACKPORCH_LSB +: 9];
      c.v_total      = cfg2[V_TOTAL_LSB +: 11];
      c.v_active     = cfg2[V_ACTIVE_LSB +: 11];
      c.interlaced   = cfg2[INTERLACED_BIT];
      c.v_synclen    = cfg3[V_SYNCLEN_LSB +: 4];
      c.v_backporch  = cfg3[V_BACKPORCH_LSB +: 9];
      c.v_lock_line  = cfg3[V_LOCK_LINE_LSB +: 11];
      c.framelock_en = cfg3[FRAMELOCK_EN_BIT];
      return c;
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Programmable video timing generator: H/V counters with field tracking and frame
// lock, plus registered sync/DE/coordinate decode from shadowed configuration.
module video_timing_gen
   import video_timing_pkg::*;
(
   input  logic        PCLK_i,
   input  logic        reset,
   input  logic [31:0] hv_out_config,
   input  logic [31:0] hv_out_config2,
   input  logic [31:0] hv_out_config3,
   input  logic        vlock_i,
   output logic        HSYNC_o,
   output logic        VSYNC_o,
   output logic        DE_o,
   output logic        FID_o,
   output logic [10:0] xpos_o,
   output logic [10:0] ypos_o,
   output logic        sof_o
);

   vt_cfg_t     cfg_q, cfg_d;
   logic [11:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic        fid_q, fid_d;

   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        de_q, de_d;
   logic        fid_out_q, fid_out_d;
   logic        sof_q, sof_d;
   logic [10:0] xpos_q, xpos_d;
   logic [10:0] ypos_q, ypos_d;

   logic        lock;
   logic        h_wrap;
   logic        v_last;
   logic        reload;
   logic [11:0] field_lines;

   logic        unused_cfg3_bits;
   assign unused_cfg3_bits = ^hv_out_config3[31:25];

   // Counter next-state; the >= compares keep the counters bounded if totals shrink.
   always_comb begin
      lock        = cfg_q.framelock_en & vlock_i;
      h_wrap      = h_cnt_q >= (cfg_q.h_total - 12'd1);
      field_lines = {1'b0, cfg_q.v_total};
      if (cfg_q.interlaced) begin
         if (fid_q == FID_ODD) field_lines = ({1'b0, cfg_q.v_total} + 12'd1) >> 1;
         else                  field_lines = {1'b0, cfg_q.v_total} >> 1;
      end
      v_last  = {1'b0, v_cnt_q} >= (field_lines - 12'd1);

      h_cnt_d = h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      fid_d   = fid_q;
      reload  = 1'b0;
      if (lock) begin
         h_cnt_d = 12'd0;
         v_cnt_d = cfg_q.v_lock_line;
         fid_d   = FID_ODD;
      end else if (h_wrap) begin
         h_cnt_d = 12'd0;
         if (v_last) begin
            v_cnt_d = 11'd0;
            fid_d   = cfg_q.interlaced ? ~fid_q : FID_ODD;
            reload  = (fid_d == FID_ODD);
         end else begin
            v_cnt_d = v_cnt_q + 11'd1;
         end
      end

      cfg_d = cfg_q;
      if (reset || reload) cfg_d = unpack_cfg(hv_out_config, hv_out_config2, hv_out_config3);
   end

   logic [11:0] h_half;
   logic [10:0] v_sync_end;
   logic [12:0] h_de_start, h_de_end;
   logic [11:0] v_de_start, v_de_end;

   // Output decode; EVEN interlaced fields shift the vsync edges by half a line.
   always_comb begin
      h_half     = cfg_q.h_total >> 1;
      v_sync_end = {7'd0, cfg_q.v_synclen};
      h_de_start = {5'd0, cfg_q.h_synclen} + {4'd0, cfg_q.h_backporch};
      h_de_end   = h_de_start + {1'b0, cfg_q.h_active};
      v_de_start = {8'd0, cfg_q.v_synclen} + {3'd0, cfg_q.v_backporch};
      v_de_end   = v_de_start + {1'b0, cfg_q.v_active};

      hsync_d = ~(h_cnt_q < {4'd0, cfg_q.h_synclen});
      if (fid_q == FID_ODD) begin
         vsync_d = ~(v_cnt_q < v_sync_end);
      end else begin
         vsync_d = ~(((v_cnt_q != 11'd0) || (h_cnt_q >= h_half)) &&
                     ((v_cnt_q < v_sync_end) || ((v_cnt_q == v_sync_end) && (h_cnt_q < h_half))));
      end

      de_d = ({1'b0, h_cnt_q} >= h_de_start) && ({1'b0, h_cnt_q} < h_de_end) &&
             ({1'b0, v_cnt_q} >= v_de_start) && ({1'b0, v_cnt_q} < v_de_end);

      xpos_d    = h_cnt_q[10:0] - {3'd0, cfg_q.h_synclen} - {2'd0, cfg_q.h_backporch};
      ypos_d    = v_cnt_q - {7'd0, cfg_q.v_synclen} - {2'd0, cfg_q.v_backporch};
      fid_out_d = fid_q;
      sof_d     = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0) && (fid_q == FID_ODD);
   end

   always_ff @(posedge PCLK_i) begin
      cfg_q <= cfg_d;
      if (reset) begin
         h_cnt_q   <= 12'd0;
         v_cnt_q   <= 11'd0;
         fid_q     <= FID_ODD;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         de_q      <= 1'b0;
         fid_out_q <= FID_ODD;
         sof_q     <= 1'b0;
         xpos_q    <= 11'd0;
         ypos_q    <= 11'd0;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         fid_q     <= fid_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         de_q      <= de_d;
         fid_out_q <= fid_out_d;
         sof_q     <= sof_d;
         xpos_q    <= xpos_d;
         ypos_q    <= ypos_d;
      end
   end

   assign HSYNC_o = hsync_q;
   assign VSYNC_o = vsync_q;
   assign DE_o    = de_q;
   assign FID_o   = fid_out_q;
   assign xpos_o  = xpos_q;
   assign ypos_o  = ypos_q;
   assign sof_o   = sof_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Programmable output-side video timing generator. From shadowed H/V configuration words it produces active-low HSYNC/VSYNC, DE, FID and pixel coordinates on the pixel clock. It supports progressive and interlaced (half-line-offset even-field vsync) modes, plus optional frame lock to an external per-frame pulse. It drives the scaler/output path and the test-pattern source; its config word packing mirrors the capture frontend.

## Interface
- No parameters; all timing comes from config ports.
- PCLK_i  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- hv_out_config  in  32  [11:0] H_TOTAL, [23:12] H_ACTIVE, [31:24] H_SYNCLEN.
- hv_out_config2  in  32  [8:0] H_BACKPORCH, [19:9] V_TOTAL (frame lines), [30:20] V_ACTIVE, [31] INTERLACED.
- hv_out_config3  in  32  [3:0] V_SYNCLEN, [12:4] V_BACKPORCH, [23:13] V_LOCK_LINE, [24] FRAMELOCK_EN.
- vlock_i  in  1  single-cycle frame-start pulse from the input side.
- HSYNC_o, VSYNC_o  out  1  active-low syncs.
- DE_o  out  1  active-video enable.
- FID_o  out  1  field ID: 1 = ODD, 0 = EVEN. Constant ODD in progressive mode.
- xpos_o, ypos_o  out  11  active-area coordinates.
- sof_o  out  1  one-cycle pulse at h=0, v=0 of the ODD field.

## Operation
- Config shadowing: all three words are latched into shadow registers at reset and on the cycle the counters wrap to the start of an ODD field. Mid-frame config changes have no effect until the next frame.
- h_cnt (12b): increments each cycle. When h_cnt ≥ H_TOTAL-1 it wraps to 0 and advances the line. The ≥ compare guarantees recovery after H_TOTAL shrinks.
- Field line counts:
  - Progressive: field_lines = V_TOTAL.
  - Interlaced: ODD field = (V_TOTAL+1)>>1, EVEN field = V_TOTAL>>1.
- v_cnt (11b): advances on each h wrap. When v_cnt ≥ field_lines-1 it wraps to 0.
  - Interlaced: FID toggles on each wrap.
  - Progressive: FID stays ODD.
- HSYNC_o is low while h_cnt < H_SYNCLEN.
- VSYNC_o is low while v_cnt < V_SYNCLEN.
  - ODD field: VSYNC edges occur at h_cnt = 0.
  - EVEN interlaced field: VSYNC falls and rises at h_cnt = H_TOTAL>>1 of the corresponding lines.
- DE_o = (H_SYNCLEN+H_BACKPORCH ≤ h_cnt < H_SYNCLEN+H_BACKPORCH+H_ACTIVE) AND (V_SYNCLEN+V_BACKPORCH ≤ v_cnt < V_SYNCLEN+V_BACKPORCH+V_ACTIVE).
- xpos_o = h_cnt − H_SYNCLEN − H_BACKPORCH, truncated to 11 bits.
- ypos_o = v_cnt − V_SYNCLEN − V_BACKPORCH, truncated to 11 bits.
- Both coordinates are valid only when DE_o = 1.
- Frame lock: with FRAMELOCK_EN = 1, a vlock_i pulse forces h_cnt := 0, v_cnt := V_LOCK_LINE and FID := ODD on the next cycle.
  - Lock takes precedence over a simultaneous natural wrap.
  - A lock does not reload shadow config.
  - With FRAMELOCK_EN = 0, vlock_i is ignored.

## Timing
- Counters are state; all outputs are registered from the current counter values, giving 1 cycle latency.
- Reset values:
  - h_cnt = 0, v_cnt = 0, FID = ODD.
  - Outputs during reset: HSYNC_o = 1, VSYNC_o = 1, DE_o = 0, FID_o = 1, xpos_o = 0, ypos_o = 0, sof_o = 0.
- Reset mid-frame: the counters restart on the cycle after reset deasserts. The first post-reset output cycle shows h = 0, v = 0, so HSYNC_o = 0, VSYNC_o = 0 and sof_o = 1.
- Line period is H_TOTAL cycles. Progressive frame period is H_TOTAL·V_TOTAL cycles.
- Unsupported configs: H_TOTAL < 16, V_TOTAL < 4, and sync+backporch+active ≥ total. Outputs are unspecified for these, but the counters must stay bounded and wrap.

## Structure
- Shared package video_timing_pkg holds:
  - Field bit offsets for the three config words.
  - FID_ODD/FID_EVEN constants.
  - A config-unpack function returning a packed struct used by both this block and the frontend.
- Single module. The counter and sync-decode logic stay inline; no sub-module is warranted.

## Test plan
1. Progressive: H_TOTAL=20, H_ACTIVE=8, H_SYNCLEN=2, H_BP=4, V_TOTAL=10, V_ACTIVE=4, V_SYNCLEN=2, V_BP=2.
   -> HSYNC low 2 cycles every 20; VSYNC low 40 cycles every 200; 32 DE cycles per frame; xpos 0..7; ypos 0..3; sof_o every 200 cycles; FID_o = 1 throughout.
2. Same horizontal settings, V_TOTAL=11, INTERLACED=1.
   -> ODD field 6 lines, EVEN field 5 lines; EVEN VSYNC falls at h_cnt = 10 of line 0; FID_o alternates; sof_o every 220 cycles.
3. Change H_ACTIVE 8→6 mid-frame.
   -> Current frame keeps 8-cycle DE lines; next frame after sof_o has 6-cycle DE lines.
4. FRAMELOCK_EN=1, V_LOCK_LINE=3, pulse vlock_i at h=7, v=5.
   -> Next cycle h=0, v=3; the following sof_o arrives after (10−3)·20 cycles.
5. vlock_i coincident with the natural frame wrap, V_LOCK_LINE=3.
   -> v=3 (lock wins). Repeat with FRAMELOCK_EN=0 -> natural wrap to v=0.
6. Assert reset for 3 cycles at h=12, v=7.
   -> Reset-valued outputs during reset; first cycle after: HSYNC_o = 0, VSYNC_o = 0, sof_o = 1.
